// File: rtl/decoder_pkg.sv
// Shared types and helpers for the scanning N-to-2^N decoder.
// The SCAN feature itself is gated in the top by DECODER_SCAN_EN.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int MAX_OUT = 256;
    localparam int CNT_W   = 16;

    // Bits at or above width stay clear, so callers can truncate to their own N_OUT.
    function automatic logic [MAX_OUT-1:0] onehot(input int unsigned addr, input int unsigned width);
        logic [MAX_OUT-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_OUT; i++) begin
            r[i] = (i == addr) && (i < width);
        end
        return r;
    endfunction

endpackage

// File: rtl/decoder_scan_n_core.sv
// Combinational ADDR_W -> 2^ADDR_W decode with selectable polarity.
// A deasserted valid produces the all-inactive pattern.
module decoder_core
    import decoder_pkg::*;
#(
    parameter int ADDR_W     = 3,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [ADDR_W-1:0]      addr,
    input  logic                   valid,
    output logic [(1<<ADDR_W)-1:0] y
);

    localparam int N_OUT = 1 << ADDR_W;

    logic [N_OUT-1:0] hot;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        hot = N_OUT'(onehot(32'(addr), N_OUT));
        if (!valid) begin
            hot = '0;
        end
        y = ACTIVE_LOW ? ~hot : hot;
    end

endmodule

// File: rtl/decoder_scan_n.sv
// Registered N-to-2^N decoder with valid/ready input and an optional scan walker.
// Build with DECODER_SCAN_EN defined to include SCAN mode, the dwell counter and scan_wrap.
module decoder_scan_n
    import decoder_pkg::*;
#(
    parameter int ADDR_W     = 3,
    parameter int DWELL      = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_W-1:0]      addr,
    output logic [(1<<ADDR_W)-1:0] y,
    output logic                   y_valid,
    output logic [ADDR_W-1:0]      cur_addr,
    output logic                   scan_wrap
);

    localparam int               N_OUT  = 1 << ADDR_W;
    localparam logic [N_OUT-1:0] Y_IDLE = {N_OUT{ACTIVE_LOW}};

    state_e             state_q, state_d;
    logic [N_OUT-1:0]   y_q, y_d;
    logic               y_valid_q, y_valid_d;
    logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
    logic               mode_eff;

`ifdef DECODER_SCAN_EN
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             scan_wrap_q, scan_wrap_d;

    assign mode_eff  = mode;
    assign scan_wrap = scan_wrap_q;
`else
    logic scan_cfg_unused;

    assign mode_eff        = MODE_DIRECT;
    assign scan_wrap       = 1'b0;
    assign scan_cfg_unused = mode ^ (DWELL == 0);
`endif

    assign in_ready = en & (mode_eff == MODE_DIRECT) & ~rst;

    always_comb begin
        state_d    = state_q;
        y_valid_d  = y_valid_q;
        cur_addr_d = cur_addr_q;
`ifdef DECODER_SCAN_EN
        cnt_d       = cnt_q;
        scan_wrap_d = 1'b0;
`endif
        if (!en) begin
            state_d    = IDLE;
            y_valid_d  = 1'b0;
            cur_addr_d = '0;
`ifdef DECODER_SCAN_EN
            cnt_d = '0;
        end else if (mode_eff == MODE_SCAN) begin
            // Entry from any other state restarts at address 0 with a full dwell, without a wrap pulse.
            if (state_q != SCAN) begin
                state_d    = SCAN;
                y_valid_d  = 1'b1;
                cur_addr_d = '0;
                cnt_d      = CNT_RELOAD;
            end else if (cnt_q == '0) begin
                cur_addr_d  = cur_addr_q + 1'b1;
                cnt_d       = CNT_RELOAD;
                scan_wrap_d = &cur_addr_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
`endif
        end else if (in_valid) begin
            state_d    = DIRECT;
            y_valid_d  = 1'b1;
            cur_addr_d = addr;
        end else if (state_q == SCAN) begin
            state_d    = IDLE;
            y_valid_d  = 1'b0;
            cur_addr_d = '0;
        end
    end

    decoder_core #(
        .ADDR_W     (ADDR_W),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_core (
        .addr  (cur_addr_d),
        .valid (y_valid_d),
        .y     (y_d)
    );

    // NOTE: state uses non-blocking assignments only; reset is synchronous, so it lives inside the clocked branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            y_q        <= Y_IDLE;
            y_valid_q  <= 1'b0;
            cur_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            y_q        <= y_d;
            y_valid_q  <= y_valid_d;
            cur_addr_q <= cur_addr_d;
        end
    end

`ifdef DECODER_SCAN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            scan_wrap_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            scan_wrap_q <= scan_wrap_d;
        end
    end
`endif

    assign y        = y_q;
    assign y_valid  = y_valid_q;
    assign cur_addr = cur_addr_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Scoreboard bench for decoder_scan_n (ADDR_W=3, DWELL=2, ACTIVE_LOW=1).
// Scan scenarios run when DECODER_SCAN_EN is defined; otherwise the mode-ignored behaviour is checked.
module tb_decoder_scan_n;

    typedef struct packed {
        logic [7:0] y;
        logic       v;
        logic [2:0] a;
        logic       w;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] addr = 3'd0;
    logic       in_ready;
    logic [7:0] y;
    logic       y_valid;
    logic [2:0] cur_addr;
    logic       scan_wrap;

    int   tests = 0;
    int   failed = 0;
    bit   mon_on = 1'b0;
    obs_t exp_q[$];

    decoder_scan_n #(
        .ADDR_W     (3),
        .DWELL      (2),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .addr      (addr),
        .y         (y),
        .y_valid   (y_valid),
        .cur_addr  (cur_addr),
        .scan_wrap (scan_wrap)
    );

    always #5 clk = ~clk;

    // Output must be one-hot (active low) when valid and fully blank otherwise.
    always @(negedge clk) begin
        if (mon_on) begin
            int ones;
            ones = $countones(~y);
            tests++;
            if ((y_valid && ones != 1) || (!y_valid && ones != 0) || $isunknown(y)) begin
                failed++;
                $display("FAIL onehot_or_blank: got y=%h y_valid=%b", y, y_valid);
            end
        end
    end

    function automatic obs_t mk(input int a, input bit v, input bit w);
        obs_t o;
        logic [7:0] one;
        one   = 8'h01;
        o.y   = v ? ~(one << a) : 8'hFF;
        o.v   = v;
        o.a   = v ? 3'(a) : 3'd0;
        o.w   = w;
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.y = y;
        o.v = y_valid;
        o.a = cur_addr;
        o.w = scan_wrap;
        return o;
    endfunction

    task automatic apply(input bit r, input bit e, input bit m, input bit iv, input int ad);
        rst      = r;
        en       = e;
        mode     = m;
        in_valid = iv;
        addr     = 3'(ad);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            obs_t e, g;
            apply(1, 1, 0, 1, 6);
            exp_q.push_back(mk(0, 0, 0));
            tick();
            mon_on = 1'b1;
            e = exp_q.pop_front();
            g = observe();
            tests++;
            if (g !== e || in_ready !== 1'b0) begin
                failed++;
                $display("FAIL reset[%0d]: got y=%h v=%b a=%0d w=%b rdy=%b, want y=%h v=%b a=%0d w=%b rdy=0",
                         i, g.y, g.v, g.a, g.w, in_ready, e.y, e.v, e.a, e.w);
            end
        end
    endtask

    task automatic test_direct();
        // {in_valid, addr, expected addr, expected valid}
        int stim[9][4] = '{
            '{1, 5, 5, 1}, '{0, 3, 5, 1}, '{0, 0, 5, 1}, '{1, 7, 7, 1},
            '{1, 0, 0, 1}, '{1, 1, 1, 1}, '{1, 6, 6, 1}, '{0, 2, 6, 1},
            '{1, 4, 4, 1}
        };
        for (int i = 0; i < 9; i++) begin
            obs_t e, g;
            apply(0, 1, 0, stim[i][0] != 0, stim[i][1]);
            exp_q.push_back(mk(stim[i][2], stim[i][3] != 0, 0));
            tick();
            e = exp_q.pop_front();
            g = observe();
            tests++;
            if (g !== e || in_ready !== 1'b1) begin
                failed++;
                $display("FAIL direct[%0d]: got y=%h v=%b a=%0d w=%b rdy=%b, want y=%h v=%b a=%0d w=%b rdy=1",
                         i, g.y, g.v, g.a, g.w, in_ready, e.y, e.v, e.a, e.w);
            end
        end
        begin
            obs_t e, g;
            apply(0, 0, 0, 1, 3);
            exp_q.push_back(mk(0, 0, 0));
            tick();
            e = exp_q.pop_front();
            g = observe();
            tests++;
            if (g !== e || in_ready !== 1'b0) begin
                failed++;
                $display("FAIL direct_disable: got y=%h v=%b a=%0d rdy=%b, want y=%h v=%b a=%0d rdy=0",
                         g.y, g.v, g.a, in_ready, e.y, e.v, e.a);
            end
        end
    endtask

`ifdef DECODER_SCAN_EN
    // Runs n SCAN cycles from a non-SCAN state; address = k/DWELL mod 8, wrap on the return to 0.
    task automatic run_scan(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            obs_t e, g;
            apply(0, 1, 1, 1, 5);
            exp_q.push_back(mk((k / 2) % 8, 1, (k > 0) && (k % 16 == 0)));
            tick();
            e = exp_q.pop_front();
            g = observe();
            tests++;
            if (g !== e || in_ready !== 1'b0) begin
                failed++;
                $display("FAIL %s[%0d]: got y=%h v=%b a=%0d w=%b rdy=%b, want y=%h v=%b a=%0d w=%b rdy=0",
                         tag, k, g.y, g.v, g.a, g.w, in_ready, e.y, e.v, e.a, e.w);
            end
        end
    endtask

    task automatic step_direct(input string tag, input bit e_in, input bit iv, input int ad,
                               input int ea, input bit ev);
        obs_t e, g;
        apply(0, e_in, 0, iv, ad);
        exp_q.push_back(mk(ea, ev, 0));
        tick();
        e = exp_q.pop_front();
        g = observe();
        tests++;
        if (g !== e) begin
            failed++;
            $display("FAIL %s: got y=%h v=%b a=%0d w=%b, want y=%h v=%b a=%0d w=%b",
                     tag, g.y, g.v, g.a, g.w, e.y, e.v, e.a, e.w);
        end
    endtask

    task automatic test_scan();
        run_scan("scan_walk", 34);
    endtask

    task automatic test_en_drop();
        step_direct("en_drop_idle", 0, 0, 0, 0, 0);
        run_scan("scan_to_3", 7);
        step_direct("en_drop_blank", 0, 1, 1, 0, 0);
        run_scan("scan_restart", 9);
    endtask

    task automatic test_mode_switch();
        step_direct("scan_to_direct_accept", 1, 1, 2, 2, 1);
        run_scan("direct_to_scan", 2);
        step_direct("scan_to_direct_blank", 1, 0, 7, 0, 0);
        step_direct("blank_hold", 1, 0, 7, 0, 0);
        step_direct("accept_after_blank", 1, 1, 6, 6, 1);
    endtask
`else
    task automatic test_mode_ignored();
        for (int i = 0; i < 5; i++) begin
            obs_t e, g;
            apply(0, 1, 1, i == 0, (i == 0) ? 1 : 4);
            exp_q.push_back(mk(1, 1, 0));
            tick();
            e = exp_q.pop_front();
            g = observe();
            tests++;
            if (g !== e || in_ready !== 1'b1) begin
                failed++;
                $display("FAIL mode_ignored[%0d]: got y=%h v=%b a=%0d w=%b rdy=%b, want y=%h v=%b a=%0d w=%b rdy=1",
                         i, g.y, g.v, g.a, g.w, in_ready, e.y, e.v, e.a, e.w);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_direct();
`ifdef DECODER_SCAN_EN
        test_scan();
        test_en_drop();
        test_mode_switch();
`else
        test_mode_ignored();
`endif
        test_reset();
        mon_on = 1'b0;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
